// File: rtl/camera_stream_capture.sv
// camera_stream_capture: turns the 8-bit RGB565 camera bus into 24-bit RGB
// Avalon-ST packets (one frame per packet). A small show-ahead FIFO absorbs
// sink backpressure. One FIFO slot is kept free so that an end-of-packet pad
// beat always has room when a frame is cut short by an early vsync.
module camera_stream_capture #(
  parameter int FRAME_WIDTH  = 320,
  parameter int FRAME_HEIGHT = 240,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture_enable,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic [23:0] src_data,
  output logic        src_startofpacket,
  output logic        src_endofpacket,
  output logic        src_valid,
  input  logic        src_ready,
  output logic [15:0] frame_count,
  output logic [15:0] overflow_count,
  output logic        overflow_flag
);

  localparam int COL_W = $clog2(FRAME_WIDTH + 1);
  localparam int ROW_W = $clog2(FRAME_HEIGHT + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [COL_W-1:0] COL_LIMIT   = COL_W'(FRAME_WIDTH);
  localparam logic [COL_W-1:0] COL_LAST    = COL_W'(FRAME_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LIMIT   = ROW_W'(FRAME_HEIGHT);
  localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(FRAME_HEIGHT - 1);
  localparam logic [CNT_W-1:0] CNT_RESERVE = CNT_W'(FIFO_DEPTH - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SYNC    = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // FIFO entry layout: [25] sop, [24] eop, [23:0] RGB888
  localparam logic [25:0] PAD_ENTRY = {1'b0, 1'b1, 24'h000000};

  logic             vs_r;
  logic             href_r;
  logic             href_d;
  logic [7:0]       data_r;

  logic [1:0]       state;
  logic             phase;
  logic [7:0]       hi_byte;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             written_any;
  logic             sop_pending;
  logic             pad_pending;

  logic [25:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [15:0]      pixel565;
  logic [23:0]      rgb;
  logic             pixel_done;
  logic             pix_accept;
  logic             pix_sop;
  logic             pix_eop;
  logic             room_pixel;
  logic             pix_write;
  logic             pix_drop;
  logic             early_pad;
  logic             late_pad;
  logic             fifo_wr;
  logic             fifo_rd;
  logic [25:0]      wr_entry;
  logic             eop_written;
  logic [25:0]      head_entry;

  // Pixel assembly, counter window checks and FIFO write arbitration
  always_comb begin
    pixel565    = {hi_byte, data_r};
    rgb         = {pixel565[15:11], pixel565[15:13],
                   pixel565[10:5],  pixel565[10:9],
                   pixel565[4:0],   pixel565[4:2]};
    pixel_done  = (state == ST_CAPTURE) && !vs_r && href_r && phase;
    pix_accept  = pixel_done && (col < COL_LIMIT) && (row < ROW_LIMIT);
    pix_sop     = ((col == '0) && (row == '0)) || sop_pending;
    pix_eop     = (col == COL_LAST) && (row == ROW_LAST);
    room_pixel  = count < CNT_RESERVE;
    pix_write   = pix_accept && room_pixel;
    pix_drop    = pix_accept && !room_pixel;
    early_pad   = (state == ST_CAPTURE) && vs_r && written_any;
    late_pad    = (state == ST_DONE) && pad_pending && room_pixel;
    fifo_wr     = pix_write || early_pad || late_pad;
    fifo_rd     = src_valid && src_ready;
    wr_entry    = pix_write ? {pix_sop, pix_eop, rgb} : PAD_ENTRY;
    eop_written = pix_write ? pix_eop : 1'b1;
  end

  // Show-ahead outputs straight from the head entry, forced to zero when empty
  always_comb begin
    head_entry        = fifo_mem[rd_ptr];
    src_valid         = (count != '0);
    src_data          = src_valid ? head_entry[23:0] : 24'h000000;
    src_startofpacket = src_valid && head_entry[25];
    src_endofpacket   = src_valid && head_entry[24];
  end

  // Register the camera bus once; href is kept one extra cycle to find line ends
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_r   <= 1'b0;
      href_r <= 1'b0;
      href_d <= 1'b0;
      data_r <= 8'h00;
    end else begin
      vs_r   <= cam_vsync;
      href_r <= cam_href;
      href_d <= href_r;
      data_r <= cam_data;
    end
  end

  // Frame state machine, byte phase, pixel position and sop/pad bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      phase       <= 1'b0;
      hi_byte     <= 8'h00;
      col         <= '0;
      row         <= '0;
      written_any <= 1'b0;
      sop_pending <= 1'b0;
      pad_pending <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (capture_enable && vs_r) state <= ST_SYNC;
        end
        ST_SYNC: begin
          phase       <= 1'b0;
          col         <= '0;
          row         <= '0;
          written_any <= 1'b0;
          sop_pending <= 1'b0;
          pad_pending <= 1'b0;
          if (!vs_r) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (vs_r) begin
            state <= capture_enable ? ST_SYNC : ST_IDLE;
          end else begin
            phase <= href_r ? ~phase : 1'b0;
            if (href_r && !phase) hi_byte <= data_r;
            if (href_d && !href_r) begin
              col <= '0;
              if (col != '0) row <= row + ROW_W'(1);
            end
            if (pix_accept) col <= col + COL_W'(1);
            if (pix_write) begin
              written_any <= 1'b1;
              sop_pending <= 1'b0;
            end
            if (pix_drop && pix_sop) sop_pending <= 1'b1;
            if (pix_accept && pix_eop) begin
              state <= ST_DONE;
              if (pix_drop) pad_pending <= written_any;
            end
          end
        end
        default: begin
          if (late_pad) pad_pending <= 1'b0;
          if (!pad_pending && vs_r) state <= capture_enable ? ST_SYNC : ST_IDLE;
        end
      endcase
    end
  end

  // FIFO storage; contents need no reset because valid is derived from count
  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= wr_entry;
  end

  // FIFO pointers and occupancy; write room is judged before this cycle's pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({fifo_wr, fifo_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Software-visible statistics: packets completed and pixels lost
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count    <= 16'h0000;
      overflow_count <= 16'h0000;
      overflow_flag  <= 1'b0;
    end else begin
      if (fifo_wr && eop_written) frame_count <= frame_count + 16'h0001;
      if (pix_drop) begin
        overflow_flag <= 1'b1;
        if (overflow_count != 16'hFFFF) overflow_count <= overflow_count + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_camera_stream_capture.sv
// tb_camera_stream_capture: directed and randomized frames for
// camera_stream_capture at a small geometry (4x2, 4-entry FIFO). Expected
// packets come from a line-by-line reference model of the framing rules.
module tb_camera_stream_capture;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        capture_enable;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic [23:0] src_data;
  logic        src_startofpacket;
  logic        src_endofpacket;
  logic        src_valid;
  logic        src_ready;
  logic [15:0] frame_count;
  logic [15:0] overflow_count;
  logic        overflow_flag;

  int          line_len [$];
  logic [15:0] pix [$];
  logic [25:0] exp_q [$];
  logic [25:0] got_q [$];
  int          got_base;
  int          checks;
  int          errors;
  int          exp_frames;
  int          exp_ovf;
  logic        exp_flag;

  camera_stream_capture #(
    .FRAME_WIDTH (W),
    .FRAME_HEIGHT(H),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .capture_enable   (capture_enable),
    .cam_vsync        (cam_vsync),
    .cam_href         (cam_href),
    .cam_data         (cam_data),
    .src_data         (src_data),
    .src_startofpacket(src_startofpacket),
    .src_endofpacket  (src_endofpacket),
    .src_valid        (src_valid),
    .src_ready        (src_ready),
    .frame_count      (frame_count),
    .overflow_count   (overflow_count),
    .overflow_flag    (overflow_flag)
  );

  always #5 clk = ~clk;

  // Record every accepted beat on the falling edge, away from the pop edge
  always @(negedge clk) begin
    if (!reset && src_valid && src_ready)
      got_q.push_back({src_startofpacket, src_endofpacket, src_data});
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic vs, input logic hr, input logic [7:0] d);
    cam_vsync = vs;
    cam_href  = hr;
    cam_data  = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] expand565(input logic [15:0] p);
    int r, g, b;
    r = (int'(p) / 2048) % 32;
    g = (int'(p) / 32) % 64;
    b = int'(p) % 32;
    return {8'(r * 8 + r / 4), 8'(g * 4 + g / 16), 8'(b * 8 + b / 4)};
  endfunction

  // Reference: walk the lines, keep the first W pixels of each of the first H
  // lines, mark (0,0) and (W-1,H-1), and pad if the frame ends early.
  task automatic buildExpected();
    int   r, k;
    bit   done, written;
    r = 0; k = 0; done = 0; written = 0;
    foreach (line_len[i]) begin
      int c;
      c = 0;
      for (int j = 0; j < line_len[i]; j++) begin
        logic [15:0] p;
        p = pix[k];
        k++;
        if (!done && r < H && c < W) begin
          bit s, e;
          s = (r == 0 && c == 0);
          e = (r == H - 1 && c == W - 1);
          exp_q.push_back({s, e, expand565(p)});
          written = 1;
          if (e) begin
            done = 1;
            exp_frames++;
          end
          c++;
        end
      end
      if (c > 0) r++;
    end
    if (!done && written) begin
      exp_q.push_back({1'b0, 1'b1, 24'h000000});
      exp_frames++;
    end
  endtask

  task automatic beginTest();
    line_len.delete();
    pix.delete();
    exp_q.delete();
    got_base = got_q.size();
  endtask

  task automatic randomPixels(input int n);
    for (int i = 0; i < n; i++) pix.push_back(16'($urandom));
  endtask

  task automatic sendFrame(input int dropEnableAfter);
    int k;
    k = 0;
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);
    foreach (line_len[i]) begin
      for (int j = 0; j < line_len[i]; j++) begin
        logic [15:0] p;
        p = pix[k];
        k++;
        applyStimulus(1'b0, 1'b1, p[15:8]);
        applyStimulus(1'b0, 1'b1, p[7:0]);
      end
      repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
      if (i == dropEnableAfter) capture_enable = 1'b0;
    end
    repeat (2) applyStimulus(1'b1, 1'b0, 8'h00);
  endtask

  task automatic drainAndCompare(input string tag);
    int n, got;
    src_ready = 1'b1;
    n = 0;
    while ((got_q.size() - got_base) < exp_q.size() && n < 100) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      n++;
    end
    repeat (4) applyStimulus(1'b1, 1'b0, 8'h00);
    got = got_q.size() - got_base;
    checkOutput({tag, "_beats"}, 32'(got), 32'(exp_q.size()));
    for (int i = 0; i < got && i < exp_q.size(); i++)
      checkOutput($sformatf("%s_beat%0d", tag, i), 32'(got_q[got_base + i]), 32'(exp_q[i]));
    checkOutput({tag, "_frame_count"}, 32'(frame_count), 32'(exp_frames % 65536));
    checkOutput({tag, "_overflow_count"}, 32'(overflow_count), 32'(exp_ovf));
    checkOutput({tag, "_overflow_flag"}, 32'(overflow_flag), 32'(exp_flag));
  endtask

  initial begin
    checks = 0; errors = 0; exp_frames = 0; exp_ovf = 0; exp_flag = 1'b0;
    got_base = 0;
    reset = 1'b1; capture_enable = 1'b1; src_ready = 1'b0;
    cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] reset state");
    checkOutput("rst_valid", 32'(src_valid), 32'd0);
    checkOutput("rst_data", 32'(src_data), 32'd0);
    checkOutput("rst_sop", 32'(src_startofpacket), 32'd0);
    checkOutput("rst_eop", 32'(src_endofpacket), 32'd0);
    checkOutput("rst_frame_count", 32'(frame_count), 32'd0);
    checkOutput("rst_overflow_count", 32'(overflow_count), 32'd0);
    checkOutput("rst_overflow_flag", 32'(overflow_flag), 32'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00);

    $display("[TB] full red frame");
    beginTest();
    line_len = '{W, W};
    repeat (W * H) pix.push_back(16'hF800);
    buildExpected();
    src_ready = 1'b1;
    sendFrame(-1);
    drainAndCompare("red");
    checkOutput("red_first_data", 32'(got_q[got_base][23:0]), 32'h00FF0000);

    $display("[TB] latency with green then blue");
    beginTest();
    line_len = '{2};
    pix = '{16'h07E0, 16'h001F};
    buildExpected();
    src_ready = 1'b0;
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h07);
    applyStimulus(1'b0, 1'b1, 8'hE0);
    checkOutput("lat_not_yet_valid", 32'(src_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("lat_valid", 32'(src_valid), 32'd1);
    checkOutput("lat_data", 32'(src_data), 32'h0000FF00);
    checkOutput("lat_sop", 32'(src_startofpacket), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h1F);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    repeat (2) applyStimulus(1'b1, 1'b0, 8'h00);
    drainAndCompare("latency");

    $display("[TB] backpressure for a whole frame");
    beginTest();
    line_len = '{W, W};
    randomPixels(W * H);
    buildExpected();
    while (exp_q.size() > DEPTH - 1) void'(exp_q.pop_back());
    exp_q.push_back({1'b0, 1'b1, 24'h000000});
    exp_ovf  = exp_ovf + W * H - (DEPTH - 1);
    exp_flag = 1'b1;
    src_ready = 1'b0;
    sendFrame(-1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("hold_data%0d", i), 32'(src_data), 32'(exp_q[0][23:0]));
      checkOutput($sformatf("hold_sop%0d", i), 32'(src_startofpacket), 32'd1);
      applyStimulus(1'b1, 1'b0, 8'h00);
    end
    checkOutput("hold_no_pad_yet", 32'(frame_count), 32'((exp_frames - 1) % 65536));
    checkOutput("hold_overflow_count", 32'(overflow_count), 32'(exp_ovf));
    drainAndCompare("overflow");

    $display("[TB] overlong first line");
    beginTest();
    line_len = '{W + 2, W};
    randomPixels(2 * W + 2);
    buildExpected();
    sendFrame(-1);
    drainAndCompare("long_line");

    $display("[TB] early vsync after three pixels");
    beginTest();
    line_len = '{3};
    randomPixels(3);
    buildExpected();
    sendFrame(-1);
    drainAndCompare("early_vsync");

    $display("[TB] enable dropped mid-frame");
    beginTest();
    line_len = '{W, W};
    randomPixels(W * H);
    buildExpected();
    sendFrame(0);
    drainAndCompare("enable_drop");

    $display("[TB] frame while disabled");
    beginTest();
    line_len = '{W, W};
    randomPixels(W * H);
    sendFrame(-1);
    drainAndCompare("disabled");
    capture_enable = 1'b1;

    $display("[TB] randomized frames");
    for (int f = 0; f < 8; f++) begin
      int nl, total;
      beginTest();
      nl = int'($urandom_range(3, 1));
      total = 0;
      for (int l = 0; l < nl; l++) begin
        int len;
        len = int'($urandom_range(W + 2, 1));
        line_len.push_back(len);
        total += len;
      end
      randomPixels(total);
      buildExpected();
      sendFrame(-1);
      drainAndCompare($sformatf("rand%0d", f));
    end

    $display("[TB] reset in the middle of a frame");
    beginTest();
    src_ready = 1'b0;
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);
    repeat (2) begin
      applyStimulus(1'b0, 1'b1, 8'h12);
      applyStimulus(1'b0, 1'b1, 8'h34);
    end
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("pre_reset_valid", 32'(src_valid), 32'd1);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("mid_reset_valid", 32'(src_valid), 32'd0);
    checkOutput("mid_reset_data", 32'(src_data), 32'd0);
    checkOutput("mid_reset_frame_count", 32'(frame_count), 32'd0);
    checkOutput("mid_reset_overflow_count", 32'(overflow_count), 32'd0);
    checkOutput("mid_reset_overflow_flag", 32'(overflow_flag), 32'd0);
    reset = 1'b0;
    exp_frames = 0; exp_ovf = 0; exp_flag = 1'b0;
    src_ready = 1'b1;
    got_base = got_q.size();
    repeat (W) begin
      applyStimulus(1'b0, 1'b1, 8'hAB);
      applyStimulus(1'b0, 1'b1, 8'hCD);
    end
    repeat (4) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("no_capture_before_vsync", 32'(got_q.size() - got_base), 32'd0);
    beginTest();
    line_len = '{W, W};
    randomPixels(W * H);
    buildExpected();
    sendFrame(-1);
    drainAndCompare("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/camera_stream_capture.md
# camera_stream_capture

Captures the 8-bit RGB565 camera bus on the pixel clock and converts it to 24-bit RGB Avalon-ST video packets for the video DMA sink (`video_dma_sink_*` on the system top). It sits directly upstream of the DMA: one frame becomes one packet. Packets are framed with startofpacket/endofpacket and buffered through a small FIFO to absorb sink backpressure. Overflow and frame statistics are exported for software via PIO.

## Interface
- FRAME_WIDTH, 320, pixels per line accepted
- FRAME_HEIGHT, 240, lines per frame accepted
- FIFO_DEPTH, 16, output FIFO entries (power of 2, ≥4)
- clk  in  1  pixel clock (camera PCLK domain); all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- capture_enable  in  1  level; frames start/stop only on frame boundaries
- cam_vsync  in  1  high = vertical blank
- cam_href  in  1  high = valid line bytes
- cam_data  in  8  RGB565 byte stream, high byte first
- src_data  out  24  {R8,G8,B8}, R in [23:16]
- src_startofpacket  out  1  first pixel of frame
- src_endofpacket  out  1  last pixel of frame (or pad beat)
- src_valid  out  1  FIFO non-empty
- src_ready  in  1  sink accepts beat when valid&&ready
- frame_count  out  16  completed packets, wraps 0xFFFF→0
- overflow_count  out  16  pixels dropped on full FIFO, saturates at 0xFFFF
- overflow_flag  out  1  sticky, set on any drop; cleared only by reset

## Operation
- cam_vsync/href/data registered once at input; all decisions use registered copies.
- States: IDLE → (enable && vsync high) → SYNC → (vsync falls) → CAPTURE → (pixel index = W*H−1 written/dropped) → DONE → (vsync high) → SYNC if enable, else IDLE.
- CAPTURE: byte phase toggles on each href-high cycle, reset to 0 when href low; phase 0 latches high byte, phase 1 completes pixel.
- Expansion: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
- Pixel counters: col 0..FRAME_WIDTH−1, row 0..FRAME_HEIGHT−1. Pixels with col ≥ FRAME_WIDTH in a line are discarded (no count). col resets on href falling edge; row increments on href falling edge if col>0.
- sop=1 on pixel (0,0); eop=1 on pixel (W−1,H−1). Lines short of FRAME_WIDTH are not padded; row still advances.
- FIFO write only if occupancy < FIFO_DEPTH−1 (one slot reserved). Otherwise pixel dropped, counters still advance, overflow_count++, overflow_flag=1. A dropped sop pixel is forced onto the next written pixel of the frame; a dropped eop pixel is replaced by the pad beat.
- Early vsync (vsync rises in CAPTURE): if ≥1 beat written this frame, write pad beat data=0, eop=1 into the reserved slot, then go to SYNC/IDLE. If none written, no beat.
- frame_count increments on each eop beat written to the FIFO (normal or pad).
- capture_enable falling mid-frame: current frame completes normally.
- FIFO: show-ahead; src_* driven directly from head entry; pop on src_valid && src_ready.

## Timing
- Reset: state IDLE, FIFO empty, src_valid=0, src_data=0, sop=0, eop=0, all counters 0, overflow_flag=0.
- Latency: second pixel byte on bus at edge t → in input reg after t → FIFO write at t+1 → src_valid=1 from t+2 (FIFO initially empty).
- Throughput: 1 pixel per 2 clocks in; sink may pop 1 per clock.
- Simultaneous write and pop at full-reserve threshold: occupancy is evaluated before the pop (conservative drop).
- src_data/sop/eop held stable while src_valid && !src_ready.

## Test plan
- W=4,H=2, src_ready=1, bytes 0xF8,0x00 per pixel → 8 beats of 0xFF0000, sop on beat 0 only, eop on beat 7, frame_count=1.
- Bytes 0x07,0xE0 then 0x00,0x1F → beats 0x00FF00 then 0x0000FF; first valid exactly 2 clocks after the second byte edge.
- W=4,H=2, FIFO_DEPTH=4, src_ready=0 for whole frame → 3 beats held, overflow_count=5, overflow_flag=1, eop pad beat absent until a slot frees; release ready → beats stable and in order.
- Line with 6 pixels at W=4 → pixels 4,5 discarded; next line starts at col 0.
- vsync rises after 3 pixels of W=4,H=2 → 3 pixel beats then pad beat 0x000000 with eop, frame_count=1.
- reset asserted mid-frame with FIFO holding 2 beats → next cycle src_valid=0, counters 0; capture resumes only after a full vsync high→low.
